// File: rtl/mips_alu_pkg.sv
// Shared EX-stage ALU control codes and the multiply sequencer's state encoding.
package mips_alu_pkg;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ITER  = 3'd1;
    localparam logic [2:0] ST_DONE  = 3'd2;
    localparam logic [2:0] ST_FIX_A = 3'd3;
    localparam logic [2:0] ST_FIX_B = 3'd4;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/response bus of the multiply sequencer; mul_signed exists only with ALU_MUL_SIGNED_EN.
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
`ifdef ALU_MUL_SIGNED_EN
    logic             mul_signed;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;

`ifdef ALU_MUL_SIGNED_EN
    modport master (output start, op_a, op_b, mul_signed, input busy, done, prod_hi, prod_lo);
    modport slave  (input start, op_a, op_b, mul_signed, output busy, done, prod_hi, prod_lo);
`else
    modport master (output start, op_a, op_b, input busy, done, prod_hi, prod_lo);
    modport slave  (input start, op_a, op_b, output busy, done, prod_hi, prod_lo);
`endif

endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier that borrows the shared EX-stage ALU; result lands in HI/LO.
// Define ALU_MUL_SIGNED_EN to add the mul_signed request bit and the FIX_A/FIX_B sign-fix states.
module alu_mul_sequencer
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_mul_sequencer_if.slave bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             alu_own,
    output logic             stall
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [2:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   prod_hi_q;
    logic [WIDTH-1:0]   prod_lo_q;
`ifdef ALU_MUL_SIGNED_EN
    logic               neg;
`endif

    logic               accept;
    logic               busy_i;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [2*WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] product;

    assign accept = bus.start && (state == ST_IDLE || state == ST_DONE);
    assign busy_i = (state != ST_IDLE) && (state != ST_DONE);

    // The ALU adds without a carry-out, so the carry is recovered from unsigned wrap-around.
    always_comb begin
        sum   = lo[0] ? alu_result : hi;
        carry = lo[0] && (alu_result < hi);
    end

    assign shifted = {carry, sum, lo[WIDTH-1:1]};
`ifdef ALU_MUL_SIGNED_EN
    assign product = neg ? -shifted : shifted;
`else
    assign product = shifted;
`endif

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        case (state)
            ST_ITER: begin
                alu_a    = hi;
                alu_b    = mcand;
                alu_ctrl = ALU_ADD;
            end
`ifdef ALU_MUL_SIGNED_EN
            ST_FIX_A: begin
                alu_b    = mcand;
                alu_ctrl = ALU_SUB;
            end
            ST_FIX_B: begin
                alu_b    = lo;
                alu_ctrl = ALU_SUB;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every update sees the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
`ifdef ALU_MUL_SIGNED_EN
            neg       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        mcand <= bus.op_a;
                        hi    <= '0;
                        lo    <= bus.op_b;
                        cnt   <= '0;
`ifdef ALU_MUL_SIGNED_EN
                        neg   <= bus.mul_signed && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        state <= bus.mul_signed ? ST_FIX_A : ST_ITER;
`else
                        state <= ST_ITER;
`endif
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ITER: begin
                    hi  <= shifted[2*WIDTH-1:WIDTH];
                    lo  <= shifted[WIDTH-1:0];
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state     <= ST_DONE;
                        prod_hi_q <= product[2*WIDTH-1:WIDTH];
                        prod_lo_q <= product[WIDTH-1:0];
                    end
                end
`ifdef ALU_MUL_SIGNED_EN
                // Both fix states always run so signed latency does not depend on the operands.
                ST_FIX_A: begin
                    if (mcand[WIDTH-1]) mcand <= alu_result;
                    state <= ST_FIX_B;
                end
                ST_FIX_B: begin
                    if (lo[WIDTH-1]) lo <= alu_result;
                    state <= ST_ITER;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_i;
    assign bus.done    = (state == ST_DONE);
    assign bus.prod_hi = prod_hi_q;
    assign bus.prod_lo = prod_lo_q;
    assign stall       = busy_i;
    assign alu_own     = busy_i;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench: a behavioural ALU looped back to the sequencer, results checked against plain arithmetic.
module tb_alu_mul_sequencer;
    import mips_alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_result;
    logic [2:0]   alu_ctrl;
    logic         alu_own;
    logic         stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_mul_sequencer_if #(.WIDTH(W)) bus ();

    alu_mul_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_own    (alu_own),
        .stall      (stall)
    );

    // Stand-in for the shared EX-stage ALU.
    always_comb begin
        case (alu_ctrl)
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_SLT: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        longint sa;
        longint sb;
        if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            return 64'(sa * sb);
        end
        return 64'(a) * 64'(b);
    endfunction

    task automatic set_signed(input logic sgn);
`ifdef ALU_MUL_SIGNED_EN
        bus.mul_signed = sgn;
`else
        if (sgn) $display("signed request ignored in unsigned build");
`endif
    endtask

    // Called at a negedge; presents start for one edge and returns at the negedge of cycle 1.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        set_signed(sgn);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
    endtask

    // Follows one operation from cycle 1; returns at the negedge of the done cycle.
    task automatic wait_done(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic sgn, input int inj);
        int          n   = 1;
        int          bad = 0;
        int          lat = sgn ? W + 3 : W + 1;
        logic [63:0] exp = ref_mul(a, b, sgn);
        while (bus.done !== 1'b1 && n < lat + 4) begin
            if (bus.busy !== 1'b1 || stall !== 1'b1 || alu_own !== 1'b1) bad++;
            if (n == inj) begin
                bus.start = 1'b1;
                bus.op_a  = $urandom;
                bus.op_b  = $urandom;
            end
            @(negedge clk);
            bus.start = 1'b0;
            n++;
        end
        check({tag, "_done_cycle"}, 64'(n), 64'(lat));
        check({tag, "_busy_window"}, 64'(bad), 64'd0);
        check({tag, "_idle_flags"}, {61'd0, bus.busy, stall, alu_own}, 64'd0);
        check({tag, "_product"}, {bus.prod_hi, bus.prod_lo}, exp);
    endtask

    task automatic done_pulse_ends(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         seen;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        set_signed(1'b0);
        #1;
        check("reset_flags", {60'd0, bus.busy, bus.done, stall, alu_own}, 64'd0);
        check("reset_product", {bus.prod_hi, bus.prod_lo}, 64'd0);
        check("reset_alu_drive", {29'd0, alu_ctrl, alu_a}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T1 and T2: small product and the all-ones carry case.
        launch(32'd3, 32'd5, 1'b0);
        check("t1_alu_ctrl", 64'(alu_ctrl), 64'(ALU_ADD));
        wait_done("t1", 32'd3, 32'd5, 1'b0, 0);
        done_pulse_ends("t1");
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        check("t2_literal", {bus.prod_hi, bus.prod_lo}, 64'hFFFF_FFFE_0000_0001);
        done_pulse_ends("t2");

        // T3: start while busy must be ignored.
        launch(32'd3, 32'd5, 1'b0);
        wait_done("t3", 32'd3, 32'd5, 1'b0, 10);
        done_pulse_ends("t3");

        // T4: asynchronous reset mid-operation.
        launch(32'd123, 32'd456, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4_abort_flags", {61'd0, bus.busy, stall, alu_own}, 64'd0);
        check("t4_abort_product", {bus.prod_hi, bus.prod_lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= bus.done;
        end
        check("t4_no_done", {63'd0, seen}, 64'd0);

        // T5: back-to-back start accepted in the DONE cycle.
        launch(32'd11, 32'd13, 1'b0);
        wait_done("t5a", 32'd11, 32'd13, 1'b0, 0);
        launch(32'd7, 32'd6, 1'b0);
        wait_done("t5b", 32'd7, 32'd6, 1'b0, 0);
        check("t5_lo42", 64'(bus.prod_lo), 64'd42);
        done_pulse_ends("t5b");

        // Random unsigned operands, including zero operands and back-to-back chains.
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 0) a = '0;
            if (i == 1) b = '0;
            launch(a, b, 1'b0);
            wait_done("rnd", a, b, 1'b0, (i % 4 == 3) ? 5 + i : 0);
            if (i % 3 != 2) done_pulse_ends("rnd");
        end
        if (bus.done === 1'b1) done_pulse_ends("rnd_tail");

`ifdef ALU_MUL_SIGNED_EN
        // T6 and random mixed signed/unsigned requests.
        launch(32'hFFFF_FFFD, 32'd7, 1'b1);
        wait_done("t6", 32'hFFFF_FFFD, 32'd7, 1'b1, 0);
        check("t6_literal", {bus.prod_hi, bus.prod_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        done_pulse_ends("t6");
        for (int i = 0; i < 8; i++) begin
            logic sgn;
            a   = $urandom;
            b   = $urandom;
            sgn = (i % 2 == 0);
            if (i == 0) a = 32'h8000_0000;
            if (i == 2) b = 32'h8000_0000;
            launch(a, b, sgn);
            wait_done("rnd_s", a, b, sgn, 0);
            done_pulse_ends("rnd_s");
        end
        set_signed(1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
